l1_inst_cache_assoc: RTL

- N-way set-associative L1 instruction cache with one outstanding miss.
- Extends the direct-mapped L1 I-cache with:
  - configurable associativity;
  - per-set round-robin replacement;
  - a whole-cache invalidate port (for self-modifying code or firmware reload);
  - refill error propagation.
- Sits between the fetch stage of a compute unit or the control processor and the external memory / OSPI refill path.

---
 rtl/l1_inst_cache_assoc_if.sv | 41 ++++
 rtl/l1_inst_cache_assoc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_inst_cache_assoc_if.sv
// l1_inst_cache_assoc_if
// Bundles the I-cache ports: the fetch request/response path, the
// whole-cache invalidate, the single-beat line refill path and the
// performance counters.
//   slave  : the cache side (drives req_ready, resp_*, inv_busy, miss_req_*, perf_*)
//   master : the environment side (fetch stage, invalidate source, refill memory)
interface l1_inst_cache_assoc_if #(
  parameter int FETCH_DATA_BITS = 32,
  parameter int LINE_BYTES      = 32
);
  logic                       req_valid;
  logic [31:0]                req_addr;
  logic                       req_ready;
  logic                       resp_valid;
  logic [FETCH_DATA_BITS-1:0] resp_data;
  logic                       resp_err;
  logic                       inv_req;
  logic                       inv_busy;
  logic                       miss_req_valid;
  logic [31:0]                miss_req_addr;
  logic                       miss_req_ready;
  logic                       miss_resp_valid;
  logic [LINE_BYTES*8-1:0]    miss_resp_data;
  logic                       miss_resp_err;
  logic [31:0]                perf_hits;
  logic [31:0]                perf_misses;

  modport slave (
    input  req_valid, req_addr, inv_req,
           miss_req_ready, miss_resp_valid, miss_resp_data, miss_resp_err,
    output req_ready, resp_valid, resp_data, resp_err, inv_busy,
           miss_req_valid, miss_req_addr, perf_hits, perf_misses
  );

  modport master (
    output req_valid, req_addr, inv_req,
           miss_req_ready, miss_resp_valid, miss_resp_data, miss_resp_err,
    input  req_ready, resp_valid, resp_data, resp_err, inv_busy,
           miss_req_valid, miss_req_addr, perf_hits, perf_misses
  );
endinterface

// File: rtl/l1_inst_cache_assoc.sv
// l1_inst_cache_assoc
// N-way set-associative L1 instruction cache, one outstanding miss,
// per-set round-robin replacement, whole-cache invalidate sweep and
// refill error propagation.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : l1_inst_cache_assoc_if.slave (fetch req/resp, inv_req/inv_busy,
//              miss_req_*/miss_resp_*, perf_hits/perf_misses)
// Optional build macro L1I_ASSOC_PERF_EN: enables the hit/miss counters;
// when undefined the perf ports read 0 and no counter flops exist.
//
// state       | meaning
// S_IDLE      | ready for a fetch; an invalidate request starts the sweep
// S_LOOKUP    | tag/data RAM outputs valid, compare all ways
// S_MISS_REQ  | presenting the line refill request
// S_MISS_WAIT | waiting for the single-beat refill response
// S_FLUSH     | clearing valid bits, one set per cycle
module l1_inst_cache_assoc #(
  parameter int WAYS            = 2,
  parameter int SETS            = 32,
  parameter int LINE_BYTES      = 32,
  parameter int FETCH_DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  l1_inst_cache_assoc_if.slave bus
);

  localparam int OB        = $clog2(LINE_BYTES);
  localparam int IB        = $clog2(SETS);
  localparam int TB        = 32 - OB - IB;
  localparam int FB        = $clog2(FETCH_DATA_BITS / 8);
  localparam int NWORDS    = LINE_BYTES * 8 / FETCH_DATA_BITS;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int VB        = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            inv_pend_q, inv_pend_d;
  logic [IB-1:0]   flush_cnt_q, flush_cnt_d;
  logic [VB-1:0]   victim_way_q, victim_way_d;
  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] valid_d [WAYS];
  logic [VB-1:0]   ptr_q [SETS];
  logic [VB-1:0]   ptr_d [SETS];

  logic [TB-1:0]        tag_mem  [WAYS][SETS];
  logic [LINE_BITS-1:0] data_mem [WAYS][SETS];
  logic [TB-1:0]        tag_rd   [WAYS];
  logic [LINE_BITS-1:0] data_rd  [WAYS];

  logic [IB-1:0] idx_q, req_idx;
  logic [TB-1:0] tag_q;
  logic [OB-1:0] off_q;
  assign idx_q   = addr_q[OB +: IB];
  assign tag_q   = addr_q[31 -: TB];
  assign off_q   = addr_q[OB-1:0];
  assign req_idx = bus.req_addr[OB +: IB];

  logic                       rd_en, install, refill_done, go_flush;
  logic                       lookup_hit, lookup_miss;
  logic                       hit_any, inv_found;
  logic [VB-1:0]              first_inv;
  logic [LINE_BITS-1:0]       hit_line;
  logic                       req_ready_o, resp_valid_o, resp_err_o, miss_req_valid_o, inv_busy_o;
  logic [FETCH_DATA_BITS-1:0] resp_data_o;

  function automatic logic [FETCH_DATA_BITS-1:0] pick_word(
    input logic [LINE_BITS-1:0] line,
    input logic [OB-1:0]        off
  );
    logic [FETCH_DATA_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (int'(off >> FB) == i) w = line[i*FETCH_DATA_BITS +: FETCH_DATA_BITS];
    end
    return w;
  endfunction

  function automatic logic [VB-1:0] ptr_inc(input logic [VB-1:0] p);
    return (p == VB'(WAYS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Way compare and victim candidate; the way loop runs downward so the
  // lowest-numbered invalid way is the one that sticks.
  always_comb begin
    hit_any   = 1'b0;
    hit_line  = '0;
    inv_found = 1'b0;
    first_inv = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx_q] && (tag_rd[w] == tag_q)) begin
        hit_any  = 1'b1;
        hit_line = hit_line | data_rd[w];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx_q]) begin
        inv_found = 1'b1;
        first_inv = VB'(w);
      end
    end
  end

  assign inv_busy_o = inv_pend_q || (state_q == S_FLUSH);

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    inv_pend_d       = inv_pend_q | bus.inv_req;
    flush_cnt_d      = flush_cnt_q;
    victim_way_d     = victim_way_q;
    valid_d          = valid_q;
    ptr_d            = ptr_q;
    rd_en            = 1'b0;
    install          = 1'b0;
    refill_done      = 1'b0;
    go_flush         = 1'b0;
    lookup_hit       = 1'b0;
    lookup_miss      = 1'b0;
    req_ready_o      = 1'b0;
    resp_valid_o     = 1'b0;
    resp_data_o      = '0;
    resp_err_o       = 1'b0;
    miss_req_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = !inv_busy_o && !bus.inv_req;
        if (bus.inv_req) begin
          go_flush = 1'b1;
        end else if (bus.req_valid && !inv_busy_o) begin
          addr_d  = bus.req_addr;
          rd_en   = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          lookup_hit   = 1'b1;
          resp_valid_o = 1'b1;
          resp_data_o  = pick_word(hit_line, off_q);
          if (inv_pend_q || bus.inv_req) go_flush = 1'b1;
          else                           state_d  = S_IDLE;
        end else begin
          // An invalidate seen here waits until the refill has installed.
          lookup_miss  = 1'b1;
          victim_way_d = inv_found ? first_inv : ptr_q[idx_q];
          state_d      = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        miss_req_valid_o = 1'b1;
        if (bus.miss_req_ready) begin
          state_d     = S_MISS_WAIT;
          refill_done = bus.miss_resp_valid;
        end
      end
      S_MISS_WAIT: begin
        refill_done = bus.miss_resp_valid;
      end
      S_FLUSH: begin
        for (int w = 0; w < WAYS; w++) valid_d[w][flush_cnt_q] = 1'b0;
        ptr_d[flush_cnt_q] = '0;
        if (flush_cnt_q == '0) begin
          if (inv_pend_q || bus.inv_req) go_flush = 1'b1;
          else                           state_d  = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Refill completion: bypass the requested word straight to the fetch stage.
    if (refill_done) begin
      resp_valid_o = 1'b1;
      resp_data_o  = pick_word(bus.miss_resp_data, off_q);
      resp_err_o   = bus.miss_resp_err;
      if (!bus.miss_resp_err) begin
        install                        = 1'b1;
        valid_d[victim_way_q][idx_q]   = 1'b1;
        ptr_d[idx_q]                   = ptr_inc(ptr_q[idx_q]);
      end
      if (inv_pend_q || bus.inv_req) go_flush = 1'b1;
      else                           state_d  = S_IDLE;
    end

    if (go_flush) begin
      state_d     = S_FLUSH;
      flush_cnt_d = IB'(SETS - 1);
      inv_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      inv_pend_q   <= 1'b0;
      flush_cnt_q  <= '0;
      victim_way_q <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inv_pend_q   <= inv_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      victim_way_q <= victim_way_d;
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
    end
  end

  // Tag and data arrays: synchronous read, no reset.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_rd[w]  <= tag_mem[w][req_idx];
        data_rd[w] <= data_mem[w][req_idx];
      end
    end
    if (install) begin
      tag_mem[victim_way_q][idx_q]  <= tag_q;
      data_mem[victim_way_q][idx_q] <= bus.miss_resp_data;
    end
  end

`ifdef L1I_ASSOC_PERF_EN
  logic [31:0] perf_hits_q, perf_hits_d, perf_misses_q, perf_misses_d;

  always_comb begin
    perf_hits_d   = perf_hits_q;
    perf_misses_d = perf_misses_q;
    if (bus.inv_req) begin
      perf_hits_d   = '0;
      perf_misses_d = '0;
    end else begin
      if (lookup_hit)  perf_hits_d   = perf_hits_q + 32'd1;
      if (lookup_miss) perf_misses_d = perf_misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
    end
  end

  assign bus.perf_hits   = perf_hits_q;
  assign bus.perf_misses = perf_misses_q;
`else
  assign bus.perf_hits   = '0;
  assign bus.perf_misses = '0;
`endif

  assign bus.req_ready      = req_ready_o;
  assign bus.resp_valid     = resp_valid_o;
  assign bus.resp_data      = resp_data_o;
  assign bus.resp_err       = resp_err_o;
  assign bus.inv_busy       = inv_busy_o;
  assign bus.miss_req_valid = miss_req_valid_o;
  assign bus.miss_req_addr  = {tag_q, idx_q, {OB{1'b0}}};

endmodule
